// File: rtl/playfield_row_if.sv
// Bundles one playfield row's controller-facing signals: shift chain, writes, probes, clear and GPU read.
// Latency: none, wiring only.
// Backpressure: none; the controller sequences every request itself.
interface playfield_row_if #(
   parameter int WIDTH      = 12,
   parameter int COLOR_W    = 3,
   parameter int IDX_W      = 6,
   parameter int NUM_PROBES = 4
);
   logic                        advance;
   logic [WIDTH*COLOR_W-1:0]    above_cells;
   logic [WIDTH*COLOR_W-1:0]    cells_out;
   logic                        wr_en;
   logic [IDX_W-1:0]            wr_col;
   logic [COLOR_W-1:0]          wr_color;
   logic                        row_full;
   logic [NUM_PROBES*IDX_W-1:0] probe_cols;
   logic [NUM_PROBES-1:0]       probe_hit;
   logic                        frame_tick;
   logic                        clear_req;
   logic                        clear_busy;
   logic                        clear_done;
   logic [IDX_W-1:0]            rd_col;
   logic [COLOR_W-1:0]          rd_color;

   modport master (
      output advance, above_cells, wr_en, wr_col, wr_color, probe_cols,
             frame_tick, clear_req, rd_col,
      input  cells_out, row_full, probe_hit, clear_busy, clear_done, rd_color
   );

   modport slave (
      input  advance, above_cells, wr_en, wr_col, wr_color, probe_cols,
             frame_tick, clear_req, rd_col,
      output cells_out, row_full, probe_hit, clear_busy, clear_done, rd_color
   );
endinterface

// File: rtl/playfield_row.sv
// One Tetris playfield row: colour storage, shift-in, collision probes, GPU read port, flash-then-clear sequence.
// Latency: storage updates visible next cycle; rd_color 1 cycle; clear takes FLASH_TICKS frame ticks plus 1 cycle.
// Backpressure: none; while clear_busy is high, writes, shifts and clear requests are dropped.
module playfield_row #(
   parameter int                  WIDTH       = 12,
   parameter int                  COLOR_W     = 3,
   parameter int                  IDX_W       = 6,
   parameter int                  NUM_PROBES  = 4,
   parameter logic [WIDTH-1:0]    WALL_MASK   = 12'h801,
   parameter logic [COLOR_W-1:0]  WALL_COLOR  = 3'd7,
   parameter int                  FLASH_TICKS = 6
) (
   input logic             clk,
   input logic             reset,
   playfield_row_if.slave  bus
);
   localparam int CNT_W = $clog2(FLASH_TICKS + 1);

   typedef enum logic [1:0] {IDLE, FLASH, CLEAR} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               phase_q, phase_d;
   logic               done_q;
   logic [COLOR_W-1:0] rd_q, rd_next;
   logic [COLOR_W-1:0] cells_q [WIDTH];
   logic [WIDTH*COLOR_W-1:0] cells_flat;
   logic               full;
   logic [NUM_PROBES-1:0] hit;
   logic [IDX_W-1:0]   pcol;
   logic               accept;

   // A clear is only honoured from IDLE on a completely filled row.
   assign accept = (state_q == IDLE) && bus.clear_req && full;

   // Flatten storage for the chain and derive the row-full flag.
   always_comb begin
      cells_flat = '0;
      full       = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         cells_flat[i*COLOR_W +: COLOR_W] = cells_q[i];
         full = full & (|cells_q[i]);
      end
   end

   // Probes hit occupied cells and anything beyond the right edge.
   always_comb begin
      hit  = '0;
      pcol = '0;
      for (int p = 0; p < NUM_PROBES; p++) begin
         pcol   = bus.probe_cols[p*IDX_W +: IDX_W];
         hit[p] = (pcol >= IDX_W'(WIDTH));
         for (int i = 0; i < WIDTH; i++) begin
            if (pcol == IDX_W'(i)) hit[p] = |cells_q[i];
         end
      end
   end

   // Next state: flash counts frame ticks, then a single clearing cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = FLASH;
               cnt_d   = '0;
               phase_d = 1'b0;
            end
         end
         FLASH: begin
            if (bus.frame_tick) begin
               phase_d = ~phase_q;
               if (cnt_q == CNT_W'(FLASH_TICKS - 1)) state_d = CLEAR;
               else                                 cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         CLEAR: begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer registers; clear_done is the registered image of the CLEAR cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         done_q  <= (state_q == CLEAR);
      end
   end

   // Cell storage; walls are loaded at reset and never touched again.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < WIDTH; i++)
            cells_q[i] <= WALL_MASK[i] ? WALL_COLOR : '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!WALL_MASK[i]) begin
               if (state_q == IDLE) begin
                  if (bus.wr_en && (bus.wr_col == IDX_W'(i)))
                     cells_q[i] <= bus.wr_color;
                  else if (bus.advance)
                     cells_q[i] <= bus.above_cells[i*COLOR_W +: COLOR_W];
               end else if (state_q == CLEAR) begin
                  cells_q[i] <= '0;
               end
            end
         end
      end
   end

   // GPU read mux; the flash override only paints non-wall cells.
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (bus.rd_col == IDX_W'(i))
            rd_next = (state_q == FLASH && phase_q && !WALL_MASK[i]) ? '1 : cells_q[i];
      end
   end

   // Registered GPU read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_q <= '0;
      else        rd_q <= rd_next;
   end

   assign bus.cells_out  = cells_flat;
   assign bus.row_full   = full;
   assign bus.probe_hit  = hit;
   assign bus.clear_busy = (state_q != IDLE);
   assign bus.clear_done = done_q;
   assign bus.rd_color   = rd_q;
endmodule

// File: tb/tb_playfield_row.sv
// Self-checking bench for playfield_row: bench-side cell model plus a read-port scoreboard.
// Latency: expectations for rd_color are queued when rd_col is driven and popped one edge later.
// Backpressure: not applicable; stimulus is fully sequenced by the bench.
module tb_playfield_row;
   localparam int WIDTH = 12, COLOR_W = 3, IDX_W = 6, NUM_PROBES = 4, FLASH_TICKS = 6;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   playfield_row_if #(.WIDTH(WIDTH), .COLOR_W(COLOR_W), .IDX_W(IDX_W), .NUM_PROBES(NUM_PROBES)) bus ();

   playfield_row #(
      .WIDTH(WIDTH), .COLOR_W(COLOR_W), .IDX_W(IDX_W), .NUM_PROBES(NUM_PROBES),
      .WALL_MASK(12'h801), .WALL_COLOR(3'd7), .FLASH_TICKS(FLASH_TICKS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0]         wall = 12'h801;
   logic [COLOR_W-1:0]       model [WIDTH];
   logic [COLOR_W-1:0]       rd_q [$];
   logic [COLOR_W-1:0]       rd_exp;
   logic [WIDTH*COLOR_W-1:0] exp_cells;

   function automatic logic [WIDTH*COLOR_W-1:0] pack_model();
      logic [WIDTH*COLOR_W-1:0] v;
      v = '0;
      for (int i = 0; i < WIDTH; i++) v[i*COLOR_W +: COLOR_W] = model[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < WIDTH; i++) model[i] = wall[i] ? 3'd7 : 3'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.advance     = 1'b0;
      bus.above_cells = '0;
      bus.wr_en       = 1'b0;
      bus.wr_col      = '0;
      bus.wr_color    = '0;
      bus.probe_cols  = '0;
      bus.frame_tick  = 1'b0;
      bus.clear_req   = 1'b0;
   endtask

   task automatic write_cell(input int col, input int color);
      bus.wr_en    = 1'b1;
      bus.wr_col   = IDX_W'(col);
      bus.wr_color = COLOR_W'(color);
      step();
      bus.wr_en    = 1'b0;
      if (col < WIDTH && !wall[col]) model[col] = COLOR_W'(color);
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.rd_col = '0;
      reset = 1'b0;
      #12;
      model_reset();
      exp_cells = pack_model();
      checks++;
      if (bus.cells_out !== exp_cells) begin
         errors++; $display("FAIL reset_cells: got %h want %h", bus.cells_out, exp_cells);
      end
      checks++;
      if (bus.row_full !== 1'b0) begin
         errors++; $display("FAIL reset_row_full: got %b want 0", bus.row_full);
      end
      checks++;
      if (bus.rd_color !== 3'd0) begin
         errors++; $display("FAIL reset_rd_color: got %0d want 0", bus.rd_color);
      end
      checks++;
      if (bus.clear_busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b want 0", bus.clear_busy);
      end
      checks++;
      if (bus.clear_done !== 1'b0) begin
         errors++; $display("FAIL reset_done: got %b want 0", bus.clear_done);
      end
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_write_probe();
      write_cell(5, 3);
      exp_cells = pack_model();
      checks++;
      if (bus.cells_out !== exp_cells) begin
         errors++; $display("FAIL write_col5: got %h want %h", bus.cells_out, exp_cells);
      end
      // probe0=5 (occupied), probe1=6 (empty), probe2=0 (wall), probe3=40 (off row)
      bus.probe_cols = {6'd40, 6'd0, 6'd6, 6'd5};
      #1;
      checks++;
      if (bus.probe_hit !== 4'b1101) begin
         errors++; $display("FAIL probe_hits: got %b want 1101", bus.probe_hit);
      end
      bus.rd_col = 6'd5;
      rd_q.push_back(3'd3);
      step();
      rd_exp = rd_q.pop_front();
      checks++;
      if (bus.rd_color !== rd_exp) begin
         errors++; $display("FAIL rd_col5: got %0d want %0d", bus.rd_color, rd_exp);
      end
      write_cell(0, 1);
      write_cell(20, 1);
      write_cell(11, 2);
      exp_cells = pack_model();
      checks++;
      if (bus.cells_out !== exp_cells) begin
         errors++; $display("FAIL wall_oob_write: got %h want %h", bus.cells_out, exp_cells);
      end
      bus.rd_col = 6'd20;
      rd_q.push_back(3'd0);
      step();
      rd_exp = rd_q.pop_front();
      checks++;
      if (bus.rd_color !== rd_exp) begin
         errors++; $display("FAIL rd_oob: got %0d want %0d", bus.rd_color, rd_exp);
      end
      bus.rd_col = 6'd11;
      rd_q.push_back(3'd7);
      step();
      rd_exp = rd_q.pop_front();
      checks++;
      if (bus.rd_color !== rd_exp) begin
         errors++; $display("FAIL rd_wall: got %0d want %0d", bus.rd_color, rd_exp);
      end
   endtask

   task automatic test_full_advance();
      for (int c = 1; c <= 10; c++) write_cell(c, 2);
      checks++;
      if (bus.row_full !== 1'b1) begin
         errors++; $display("FAIL row_full_set: got %b want 1", bus.row_full);
      end
      bus.advance     = 1'b1;
      bus.above_cells = '0;
      step();
      bus.advance = 1'b0;
      for (int i = 0; i < WIDTH; i++) if (!wall[i]) model[i] = 3'd0;
      exp_cells = pack_model();
      checks++;
      if (bus.cells_out !== exp_cells) begin
         errors++; $display("FAIL advance_zero: got %h want %h", bus.cells_out, exp_cells);
      end
      checks++;
      if (bus.row_full !== 1'b0) begin
         errors++; $display("FAIL row_full_clr: got %b want 0", bus.row_full);
      end
      // Non-zero shift pattern including wall positions, with a concurrent write
      for (int i = 0; i < WIDTH; i++) bus.above_cells[i*COLOR_W +: COLOR_W] = COLOR_W'((i % 6) + 1);
      bus.advance  = 1'b1;
      bus.wr_en    = 1'b1;
      bus.wr_col   = 6'd4;
      bus.wr_color = 3'd5;
      step();
      for (int i = 0; i < WIDTH; i++) if (!wall[i]) model[i] = COLOR_W'((i % 6) + 1);
      model[4] = 3'd5;
      exp_cells = pack_model();
      checks++;
      if (bus.cells_out !== exp_cells) begin
         errors++; $display("FAIL advance_write_pat: got %h want %h", bus.cells_out, exp_cells);
      end
      bus.above_cells = '0;
      step();
      bus.advance = 1'b0;
      bus.wr_en   = 1'b0;
      for (int i = 0; i < WIDTH; i++) if (!wall[i]) model[i] = 3'd0;
      model[4] = 3'd5;
      exp_cells = pack_model();
      checks++;
      if (bus.cells_out !== exp_cells) begin
         errors++; $display("FAIL advance_write_zero: got %h want %h", bus.cells_out, exp_cells);
      end
   endtask

   task automatic test_flash_clear();
      logic phase;
      logic tick;
      for (int c = 1; c <= 10; c++) write_cell(c, 2);
      bus.rd_col    = 6'd3;
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      checks++;
      if (bus.clear_busy !== 1'b1) begin
         errors++; $display("FAIL busy_after_req: got %b want 1", bus.clear_busy);
      end
      phase = 1'b0;
      for (int t = 0; t < FLASH_TICKS; t++) begin
         for (int c = 0; c < 4; c++) begin
            tick = (c == 3);
            if (t == 0 && c == 0) begin
               bus.wr_en       = 1'b1;
               bus.wr_col      = 6'd3;
               bus.wr_color    = 3'd1;
               bus.advance     = 1'b1;
               bus.above_cells = '0;
               bus.clear_req   = 1'b1;
            end
            bus.frame_tick = tick;
            rd_q.push_back(phase ? 3'd7 : model[3]);
            step();
            idle_inputs();
            rd_exp = rd_q.pop_front();
            checks++;
            if (bus.rd_color !== rd_exp) begin
               errors++; $display("FAIL flash_rd t%0d c%0d: got %0d want %0d", t, c, bus.rd_color, rd_exp);
            end
            checks++;
            if (bus.clear_busy !== 1'b1 || bus.clear_done !== 1'b0) begin
               errors++; $display("FAIL flash_busy t%0d c%0d: busy=%b done=%b want 1/0", t, c, bus.clear_busy, bus.clear_done);
            end
            if (tick) phase = ~phase;
         end
      end
      exp_cells = pack_model();
      checks++;
      if (bus.cells_out !== exp_cells) begin
         errors++; $display("FAIL flash_storage: got %h want %h", bus.cells_out, exp_cells);
      end
      rd_q.push_back(model[3]);
      step();
      for (int i = 0; i < WIDTH; i++) if (!wall[i]) model[i] = 3'd0;
      rd_exp = rd_q.pop_front();
      checks++;
      if (bus.rd_color !== rd_exp) begin
         errors++; $display("FAIL clear_rd: got %0d want %0d", bus.rd_color, rd_exp);
      end
      checks++;
      if (bus.clear_done !== 1'b1 || bus.clear_busy !== 1'b0) begin
         errors++; $display("FAIL clear_pulse: done=%b busy=%b want 1/0", bus.clear_done, bus.clear_busy);
      end
      exp_cells = pack_model();
      checks++;
      if (bus.cells_out !== exp_cells) begin
         errors++; $display("FAIL cleared_cells: got %h want %h", bus.cells_out, exp_cells);
      end
      step();
      checks++;
      if (bus.clear_done !== 1'b0) begin
         errors++; $display("FAIL done_single: got %b want 0", bus.clear_done);
      end
   endtask

   task automatic test_not_full_clear();
      bus.clear_req = 1'b1;
      bus.wr_en     = 1'b1;
      bus.wr_col    = 6'd2;
      bus.wr_color  = 3'd4;
      step();
      idle_inputs();
      model[2] = 3'd4;
      checks++;
      if (bus.clear_busy !== 1'b0) begin
         errors++; $display("FAIL notfull_busy: got %b want 0", bus.clear_busy);
      end
      exp_cells = pack_model();
      checks++;
      if (bus.cells_out !== exp_cells) begin
         errors++; $display("FAIL notfull_write: got %h want %h", bus.cells_out, exp_cells);
      end
      step();
      checks++;
      if (bus.clear_done !== 1'b0 || bus.clear_busy !== 1'b0) begin
         errors++; $display("FAIL notfull_done: done=%b busy=%b want 0/0", bus.clear_done, bus.clear_busy);
      end
   endtask

   task automatic test_reset_in_flash();
      for (int c = 1; c <= 10; c++) write_cell(c, 6);
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      checks++;
      if (bus.clear_busy !== 1'b1) begin
         errors++; $display("FAIL rif_busy: got %b want 1", bus.clear_busy);
      end
      for (int k = 0; k < 2; k++) begin
         bus.frame_tick = 1'b1;
         step();
         bus.frame_tick = 1'b0;
         step();
      end
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      exp_cells = pack_model();
      checks++;
      if (bus.cells_out !== exp_cells) begin
         errors++; $display("FAIL rif_cells: got %h want %h", bus.cells_out, exp_cells);
      end
      checks++;
      if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.rd_color !== 3'd0) begin
         errors++; $display("FAIL rif_state: busy=%b done=%b rd=%0d want 0/0/0", bus.clear_busy, bus.clear_done, bus.rd_color);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.frame_tick = (k % 2 == 0);
         step();
         checks++;
         if (bus.clear_done !== 1'b0 || bus.clear_busy !== 1'b0) begin
            errors++; $display("FAIL rif_after k%0d: done=%b busy=%b want 0/0", k, bus.clear_done, bus.clear_busy);
         end
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_probe();
      test_full_advance();
      test_flash_clear();
      test_not_full_clear();
      test_reset_in_flash();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/playfield_row.md
# playfield_row

Parametrised Tetris playfield row: WIDTH colour cells with per-column write, whole-row shift-in from the row above, collision probes, registered GPU read port and a self-timed line-clear sequence with flash animation. One instance per playfield row. The playfield controller chains rows through `cells_out`/`above_cells` and drives writes, probes and clears. Wall columns are fixed by parameter and immune to writes, shifts and clears.

## Interface
- WIDTH, 12, number of cells in the row including walls
- COLOR_W, 3, bits per cell colour; colour 0 means empty
- IDX_W, 6, width of every column index
- NUM_PROBES, 4, number of collision probes
- WALL_MASK, 12'h801, bit i set means column i is a wall
- WALL_COLOR, 3'd7, colour loaded into wall cells at reset
- FLASH_TICKS, 6, frame ticks spent flashing before a clear

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- advance  in  1  load non-wall cells from `above_cells`
- above_cells  in  WIDTH*COLOR_W  row above; cell i is bits [i*COLOR_W +: COLOR_W]
- cells_out  out  WIDTH*COLOR_W  current cell contents, same packing
- wr_en  in  1  write `wr_color` to column `wr_col`
- wr_col  in  IDX_W  write column
- wr_color  in  COLOR_W  write colour; 0 erases the cell
- row_full  out  1  every cell non-zero
- probe_cols  in  NUM_PROBES*IDX_W  probe column indices, packed like `above_cells`
- probe_hit  out  NUM_PROBES  1 when the probed cell is occupied or the index is ≥ WIDTH
- frame_tick  in  1  one-cycle pulse per video frame
- clear_req  in  1  request line clear
- clear_busy  out  1  clear sequence in progress
- clear_done  out  1  one-cycle pulse when cells have been cleared
- rd_col  in  IDX_W  GPU read column
- rd_color  out  COLOR_W  registered colour of `rd_col`

## Operation
- Reset values: wall cells = WALL_COLOR, all other cells = 0, `rd_color` = 0, `clear_busy` = 0, `clear_done` = 0, flash counter = 0, flash phase = 0, state = IDLE.
- Occupancy of a cell is colour ≠ 0.
  - `row_full` is the AND of all occupancies, combinational from storage.
  - `probe_hit` is combinational.
- State machine: IDLE, FLASH, CLEAR.
- IDLE
  - `advance` loads every non-wall cell i from `above_cells` cell i.
  - `wr_en` with `wr_col` < WIDTH on a non-wall column writes `wr_color`.
  - Writes to a wall or to `wr_col` ≥ WIDTH are ignored.
  - `advance` and `wr_en` in the same cycle: the written column takes `wr_color`, all other non-wall columns take the shift.
  - `clear_req` with `row_full` = 1 moves to FLASH: counter = 0, phase = 0, `clear_busy` = 1 from the next cycle.
  - `clear_req` with `row_full` = 0 is ignored; storage actions of that cycle still happen.
- FLASH
  - `advance`, `wr_en` and `clear_req` are ignored.
  - Each `frame_tick` toggles the phase and increments the counter.
  - When the counter reaches FLASH_TICKS − 1 and a tick arrives, move to CLEAR.
- CLEAR (one cycle)
  - Zero all non-wall cells and pulse `clear_done`.
  - Return to IDLE and drop `clear_busy` in the same edge.
- Read port
  - `rd_color` is the registered colour of `rd_col`, or 0 if `rd_col` ≥ WIDTH.
  - In FLASH with phase = 1, non-wall cells read as all-ones; wall cells are never overridden.
- `cells_out` always reflects true storage; flash never affects it.

## Timing
- Write, advance and clear take effect at the edge where they are sampled; visible on `cells_out`, `row_full` and `probe_hit` in the following cycle.
- `rd_color` latency: 1 cycle from `rd_col`.
- `clear_done` is asserted in the cycle after the CLEAR edge, concurrent with cells reading 0. `clear_busy` is high from the edge after an accepted `clear_req` until the CLEAR edge.
- Flash duration is exactly FLASH_TICKS frame ticks plus 1 cycle. With no `frame_tick`, FLASH persists indefinitely.
- Reset asserted mid-FLASH returns immediately to reset values; no `clear_done` pulse.

## Test plan
- Reset → cells_out shows col 0 and col 11 = 7, others 0; row_full = 0; rd_color = 0; clear_busy = 0.
- Write colour 3 to col 5 → next cycle probe at col 5 hits; rd_col = 5 gives rd_color = 3 one cycle later. Write to col 0 or col 20 → no change. Probe col 40 → hit.
- Fill cols 1–10 with colour 2 → row_full = 1. Then `advance` with above_cells all 0 → cols 1–10 = 0 and walls stay 7. The same cycle plus a write of 5 to col 4 → only col 4 = 5.
- Full row, clear_req → busy next cycle. Six frame_ticks 4 cycles apart: rd_color for col 3 alternates 7 (all-ones) / 2 per tick. wr_en and advance are ignored during flash. clear_done pulses once, cols 1–10 = 0, busy = 0.
- clear_req with row not full → no busy, no done. Reset during FLASH → reset state with no clear_done.
